// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding req/ack read
// to instruction memory, and drives IF/ID. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Branch_Taken,
  input  logic [ADDR_WIDTH-1:0] i_Branch_Addr,
  output logic                  o_Mem_Req,
  output logic [ADDR_WIDTH-1:0] o_Mem_Addr,
  input  logic                  i_Mem_Ack,
  input  logic [DATA_WIDTH-1:0] i_Mem_Data,
  output logic                  o_Valid,
  output logic [ADDR_WIDTH-1:0] o_PC,
  output logic [DATA_WIDTH-1:0] o_Instruction
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           o_Fetch_Count,
  output logic [31:0]           o_Flush_Count
`endif
);

  typedef enum logic [1:0] {FETCH, DISCARD, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d, tgt_q, tgt_d, skid_pc_q, skid_pc_d;
  logic [DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic                    run_q;
  logic                    valid_d, load;
  logic [ADDR_WIDTH-1:0]   opc_d, pc_inc, br_tgt;
  logic [DATA_WIDTH-1:0]   oins_d;
  logic                    ack;
  logic                    unused_br_lsb;

  // run_q keeps the request low for the first cycle after reset release
  assign o_Mem_Req     = run_q && (state_q != HOLD);
  assign o_Mem_Addr    = pc_q;
  assign ack           = o_Mem_Req && i_Mem_Ack;
  assign pc_inc        = pc_q + ADDR_WIDTH'(4);
  assign br_tgt        = {i_Branch_Addr[ADDR_WIDTH-1:2], 2'b00};
  assign unused_br_lsb = ^i_Branch_Addr[1:0];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    skid_pc_d   = skid_pc_q;
    skid_data_d = skid_data_q;
    valid_d     = i_Freeze ? o_Valid : 1'b0;
    opc_d       = o_PC;
    oins_d      = o_Instruction;
    load        = 1'b0;
    if (i_Branch_Taken) begin
      valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          // an outstanding unacked read must still be drained before redirecting
          if (!o_Mem_Req || ack) pc_d = br_tgt;
          else begin
            tgt_d   = br_tgt;
            state_d = DISCARD;
          end
        end
        DISCARD: begin
          if (ack) begin
            pc_d    = br_tgt;
            state_d = FETCH;
          end else tgt_d = br_tgt;
        end
        default: begin
          pc_d    = br_tgt;
          state_d = FETCH;
        end
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (ack) begin
            pc_d = pc_inc;
            if (!o_Valid || !i_Freeze) begin
              load    = 1'b1;
              valid_d = 1'b1;
              opc_d   = pc_inc;
              oins_d  = i_Mem_Data;
            end else begin
              skid_pc_d   = pc_inc;
              skid_data_d = i_Mem_Data;
              state_d     = HOLD;
            end
          end
        end
        DISCARD: begin
          if (ack) begin
            pc_d    = tgt_q;
            state_d = FETCH;
          end
        end
        HOLD: begin
          if (!i_Freeze) begin
            load    = 1'b1;
            valid_d = 1'b1;
            opc_d   = skid_pc_q;
            oins_d  = skid_data_q;
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      tgt_q         <= '0;
      skid_pc_q     <= '0;
      skid_data_q   <= '0;
      run_q         <= 1'b0;
      o_Valid       <= 1'b0;
      o_PC          <= '0;
      o_Instruction <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      tgt_q         <= tgt_d;
      skid_pc_q     <= skid_pc_d;
      skid_data_q   <= skid_data_d;
      run_q         <= 1'b1;
      o_Valid       <= valid_d;
      o_PC          <= opc_d;
      o_Instruction <= oins_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_Fetch_Count <= '0;
      o_Flush_Count <= '0;
    end else begin
      if (load)           o_Fetch_Count <= o_Fetch_Count + 32'd1;
      if (i_Branch_Taken) o_Flush_Count <= o_Flush_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected IF/ID loads and request
// addresses; a negedge monitor compares them as the DUT produces them.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_Freeze, i_Branch_Taken, i_Mem_Ack;
  logic [31:0] i_Branch_Addr, i_Mem_Data;
  logic        o_Mem_Req, o_Valid;
  logic [31:0] o_Mem_Addr, o_PC, o_Instruction;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] o_Fetch_Count, o_Flush_Count;
`endif

  fetch_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .i_Freeze(i_Freeze), .i_Branch_Taken(i_Branch_Taken),
    .i_Branch_Addr(i_Branch_Addr), .o_Mem_Req(o_Mem_Req), .o_Mem_Addr(o_Mem_Addr),
    .i_Mem_Ack(i_Mem_Ack), .i_Mem_Data(i_Mem_Data), .o_Valid(o_Valid), .o_PC(o_PC),
    .o_Instruction(o_Instruction)
`ifdef FETCH_PERF_CNT_EN
    , .o_Fetch_Count(o_Fetch_Count), .o_Flush_Count(o_Flush_Count)
`endif
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          errors = 0, checks = 0;
  int          credits = 0, lat = 0, cnt = 0;
  logic        acked = 1'b0, force_ack = 1'b0;
  int          n_loads = 0, n_flush = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] a, input logic [31:0] exp_pc);
    exp_t e;
    e.pc  = exp_pc;
    e.ins = mem_word(a);
    addr_q.push_back(a);
    exp_q.push_back(e);
  endtask

  // memory responder: acks after lat waiting cycles, limited to 'credits' acks
  always @(negedge clk) begin
    acked = 1'b0;
    if (force_ack) begin
      i_Mem_Ack  = 1'b1;
      i_Mem_Data = 32'hBAD0_0BAD;
    end else if (o_Mem_Req === 1'b1 && credits > 0) begin
      if (cnt >= lat) begin
        i_Mem_Ack  = 1'b1;
        i_Mem_Data = mem_word(o_Mem_Addr);
        acked      = 1'b1;
      end else begin
        cnt++;
        i_Mem_Ack = 1'b0;
      end
    end else i_Mem_Ack = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (acked) begin
      credits--;
      cnt   = 0;
      acked = 1'b0;
    end
    i_Mem_Ack  = 1'b0;
    i_Mem_Data = 32'hDEAD_BEEF;
  end

  // monitor
  logic        prev_v = 1'b0, prev_f = 1'b0, prev_br = 1'b0, prev_rst = 1'b0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_pc = '0, prev_ins = '0, prev_addr = '0;

  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      #1;
      if (!prev_rst) begin
        n_loads = 0;
        n_flush = 0;
      end
      if (prev_rst && prev_v && prev_f && !prev_br) begin
        chk("hold_valid", 64'(o_Valid), 64'd1);
        chk("hold_pc", 64'(o_PC), 64'(prev_pc));
        chk("hold_ins", 64'(o_Instruction), 64'(prev_ins));
      end else if (o_Valid === 1'b1) begin
        n_loads++;
        if (exp_q.size() == 0) chk("unexpected_load_pc", 64'(o_PC), 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("load_pc", 64'(o_PC), 64'(e.pc));
          chk("load_ins", 64'(o_Instruction), 64'(e.ins));
        end
      end
      if (prev_rst && prev_req && !prev_ack) begin
        chk("req_held", 64'(o_Mem_Req), 64'd1);
        chk("addr_stable", 64'(o_Mem_Addr), 64'(prev_addr));
      end
      if (reset && i_Mem_Ack && o_Mem_Req) begin
        if (addr_q.size() == 0) chk("unexpected_ack_addr", 64'(o_Mem_Addr), 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("ack_addr", 64'(o_Mem_Addr), 64'(addr_q.pop_front()));
      end
      if (reset && i_Branch_Taken) n_flush++;
      prev_v    = o_Valid;
      prev_f    = i_Freeze;
      prev_br   = i_Branch_Taken;
      prev_rst  = reset;
      prev_pc   = o_PC;
      prev_ins  = o_Instruction;
      prev_req  = o_Mem_Req;
      prev_addr = o_Mem_Addr;
      prev_ack  = i_Mem_Ack;
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 64'(o_Valid), 64'd0);
    chk({tag, "_pc"}, 64'(o_PC), 64'd0);
    chk({tag, "_ins"}, 64'(o_Instruction), 64'd0);
    chk({tag, "_req"}, 64'(o_Mem_Req), 64'd0);
  endtask

  initial begin
    reset = 1'b0; i_Freeze = 1'b0; i_Branch_Taken = 1'b0; i_Branch_Addr = '0;
    i_Mem_Ack = 1'b0; i_Mem_Data = '0;
    step(3);
    chk_reset_outputs("reset");

    // 1: zero-latency fetch from RESET_PC
    lat = 0; credits = 4;
    push_fetch(32'h0, 32'h4); push_fetch(32'h4, 32'h8);
    push_fetch(32'h8, 32'hC); push_fetch(32'hC, 32'h10);
    reset = 1'b1;
    step(1);
    chk("first_cycle_valid", 64'(o_Valid), 64'd0);
    step(1);
    chk("second_cycle_valid", 64'(o_Valid), 64'd1);
    step(6);

    // 2: three-cycle ack delay
    lat = 3; credits = 2;
    push_fetch(32'h10, 32'h14); push_fetch(32'h14, 32'h18);
    step(12);

    // 3: freeze for 4 cycles while valid, one word parked in the skid
    lat = 0; credits = 8;
    for (int a = 32'h18; a <= 32'h34; a += 4) push_fetch(32'(a), 32'(a + 4));
    step(2);
    i_Freeze = 1'b1;
    step(1);
    chk("hold_no_req", 64'(o_Mem_Req), 64'd0);
    step(3);
    i_Freeze = 1'b0;
    step(8);

    // 4: redirect with ack, then redirect while the 0x20 read is unacked
    credits = 1; addr_q.push_back(32'h38);
    i_Branch_Taken = 1'b1; i_Branch_Addr = 32'h20;
    step(1);
    i_Branch_Taken = 1'b0;
    chk("bubble_after_branch_ack", 64'(o_Valid), 64'd0);
    chk("redirect_addr", 64'(o_Mem_Addr), 64'h20);
    step(1);
    lat = 2;
    i_Branch_Taken = 1'b1; i_Branch_Addr = 32'h103;
    step(1);
    i_Branch_Taken = 1'b0;
    chk("bubble_after_branch", 64'(o_Valid), 64'd0);
    chk("discard_addr", 64'(o_Mem_Addr), 64'h20);
    credits = 3;
    addr_q.push_back(32'h20);
    push_fetch(32'h100, 32'h104); push_fetch(32'h104, 32'h108);
    step(15);

    // 5: branch together with freeze while holding a skid word
    lat = 0; credits = 3;
    push_fetch(32'h108, 32'h10C); push_fetch(32'h10C, 32'h110);
    addr_q.push_back(32'h110);
    step(2);
    i_Freeze = 1'b1;
    step(1);
    i_Branch_Taken = 1'b1; i_Branch_Addr = 32'h200;
    step(1);
    i_Branch_Taken = 1'b0; i_Freeze = 1'b0;
    chk("hold_branch_valid", 64'(o_Valid), 64'd0);
    chk("hold_branch_req", 64'(o_Mem_Req), 64'd1);
    chk("hold_branch_addr", 64'(o_Mem_Addr), 64'h200);
    credits = 1;
    push_fetch(32'h200, 32'h204);
    step(4);

    // 6: reset mid-request with a late ack
    lat = 3;
    reset = 1'b0;
    step(1);
    chk_reset_outputs("midreq_reset");
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt_reset", 64'(o_Fetch_Count), 64'd0);
    chk("flush_cnt_reset", 64'(o_Flush_Count), 64'd0);
`endif
    force_ack = 1'b1;
    step(1);
    chk_reset_outputs("late_ack");
    reset = 1'b1;
    step(1);
    force_ack = 1'b0;
    chk("post_reset_valid", 64'(o_Valid), 64'd0);
    chk("post_reset_req", 64'(o_Mem_Req), 64'd1);
    chk("post_reset_addr", 64'(o_Mem_Addr), 64'h0);
    lat = 0; credits = 2;
    push_fetch(32'h0, 32'h4); push_fetch(32'h4, 32'h8);
    step(6);

`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", 64'(o_Fetch_Count), 64'(n_loads));
    chk("flush_cnt", 64'(o_Flush_Count), 64'(n_flush));
`endif
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("addr_q_drained", 64'(addr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
